// File: rtl/l1_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// l1_dcache_ctrl
//   Direct-mapped, write-through, no-write-allocate L1 data-cache controller.
//   It owns the tag and valid arrays and is the only master of the external
//   cache data array. There is one word per line and 2**mem_size lines.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset
//   cpu_req/we/addr/wdata: MEM-stage access request (load or store)
//   cpu_rdata            : load data (array output on hit, fill buffer on FILL)
//   cpu_stall            : holds the pipeline; an access completes when this is 0
//   mem_req/we/addr/wdata: main-memory request (word-aligned address)
//   mem_rdata/mem_ready  : main-memory response
//   Data_Address/enable/in, Data_out : data-array pins (asynchronous read)
//   hit_count/miss_count : saturating access counters
// ---------------------------------------------------------------------------
module l1_dcache_ctrl #(
   parameter int bit_size  = 32,
   parameter int mem_size  = 5,
   parameter int addr_size = 32,
   parameter int cnt_size  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [addr_size-1:0] cpu_addr,
   input  logic [bit_size-1:0]  cpu_wdata,
   output logic [bit_size-1:0]  cpu_rdata,
   output logic                 cpu_stall,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [addr_size-1:0] mem_addr,
   output logic [bit_size-1:0]  mem_wdata,
   input  logic [bit_size-1:0]  mem_rdata,
   input  logic                 mem_ready,
   output logic [mem_size-1:0]  Data_Address,
   output logic                 Data_enable,
   output logic [bit_size-1:0]  Data_in,
   input  logic [bit_size-1:0]  Data_out,
   output logic [cnt_size-1:0]  hit_count,
   output logic [cnt_size-1:0]  miss_count
);

   localparam int LINES = 1 << mem_size;
   localparam int TAG_W = addr_size - mem_size - 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RMISS = 2'd1,
      S_FILL  = 2'd2,
      S_WMEM  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [LINES-1:0]     r_valid;
   logic [TAG_W-1:0]     r_tag [LINES];
   logic [bit_size-1:0]  r_fill_buf;
   logic [addr_size-1:0] r_addr;
   logic [bit_size-1:0]  r_wdata;
   logic [cnt_size-1:0]  r_hit_cnt;
   logic [cnt_size-1:0]  r_miss_cnt;

   logic [mem_size-1:0]  w_idx;
   logic [TAG_W-1:0]     w_tag;
   logic [mem_size-1:0]  w_ridx;
   logic [TAG_W-1:0]     w_rtag;
   logic                 w_hit;
   logic                 w_acc_hit;
   logic                 w_acc_miss;

   function automatic logic [cnt_size-1:0] sat_inc(input logic [cnt_size-1:0] v);
      if (&v)
         return v;
      else
         return v + {{(cnt_size-1){1'b0}}, 1'b1};
   endfunction

   // Lookup fields from the live CPU address and from the latched address
   assign w_idx  = cpu_addr[mem_size+1:2];
   assign w_tag  = cpu_addr[addr_size-1:mem_size+2];
   assign w_ridx = r_addr[mem_size+1:2];
   assign w_rtag = r_addr[addr_size-1:mem_size+2];

   assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_acc_hit  = (r_state == S_IDLE) && cpu_req && w_hit;
   assign w_acc_miss = (r_state == S_IDLE) && cpu_req && !w_hit;

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;

   // State register, tag/valid arrays, fill buffer and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_fill_buf <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         for (int i = 0; i < LINES; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         if (w_acc_hit)
            r_hit_cnt <= sat_inc(r_hit_cnt);
         if (w_acc_miss)
            r_miss_cnt <= sat_inc(r_miss_cnt);
         if ((r_state == S_RMISS) && mem_ready)
            r_fill_buf <= mem_rdata;
         // Tag and valid are committed on the same edge as the array write,
         // so a load to this index in the following IDLE cycle already hits.
         if (r_state == S_FILL) begin
            r_valid[w_ridx] <= 1'b1;
            r_tag[w_ridx]   <= w_rtag;
         end
      end
   end

   // Request latch: captured only when an access is accepted in IDLE, so
   // later changes on cpu_* cannot disturb an access in flight.
   always_ff @(posedge clk) begin
      if ((r_state == S_IDLE) && cpu_req) begin
         r_addr  <= cpu_addr & {{(addr_size-2){1'b1}}, 2'b00};
         r_wdata <= cpu_wdata;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (cpu_req) begin
               if (cpu_we)
                  w_next = S_WMEM;
               else if (!w_hit)
                  w_next = S_RMISS;
            end
         end
         S_RMISS: begin
            if (mem_ready)
               w_next = S_FILL;
         end
         S_FILL: begin
            w_next = S_IDLE;
         end
         S_WMEM: begin
            if (mem_ready)
               w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Output logic; while reset is held every control output is forced idle
   always_comb begin
      cpu_rdata    = Data_out;
      cpu_stall    = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      Data_Address = (r_state == S_IDLE) ? w_idx : w_ridx;
      Data_enable  = 1'b0;
      Data_in      = r_wdata;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               Data_in = cpu_wdata;
               if (cpu_req) begin
                  cpu_stall   = cpu_we || !w_hit;
                  // Write hit updates the array now; memory is written in WMEM.
                  Data_enable = cpu_we && w_hit;
               end
            end
            S_RMISS: begin
               mem_req   = 1'b1;
               mem_addr  = r_addr;
               cpu_stall = 1'b1;
            end
            S_FILL: begin
               Data_enable = 1'b1;
               Data_in     = r_fill_buf;
               cpu_rdata   = r_fill_buf;
            end
            S_WMEM: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = r_addr;
               mem_wdata = r_wdata;
               cpu_stall = !mem_ready;
            end
            default: begin
               cpu_stall = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l1_dcache_ctrl
//   Bench for l1_dcache_ctrl. Models the external data array and a main
//   memory with programmable response delay, and predicts each access from
//   a behavioural cache model (valid/tag per index, memory image, counters).
// ---------------------------------------------------------------------------
module tb_l1_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [4:0]  Data_Address;
   logic        Data_enable;
   logic [31:0] Data_in;
   logic [31:0] Data_out;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int n_chk = 0;
   int n_err = 0;

   // Device models: data array and main memory (128 words)
   logic [31:0] darr    [32];
   logic [31:0] dev_mem [128];
   int          n_wait  = 1;
   int          req_cnt = 0;
   logic        junk_rdy = 1'b0;

   // Reference model
   bit          ref_valid [32];
   logic [24:0] ref_tag   [32];
   logic [31:0] ref_mem   [128];
   int          ref_hits;
   int          ref_miss;

   always #5 clk = ~clk;

   l1_dcache_ctrl #(
      .bit_size (32),
      .mem_size (5),
      .addr_size(32),
      .cnt_size (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_stall   (cpu_stall),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .Data_Address(Data_Address),
      .Data_enable (Data_enable),
      .Data_in     (Data_in),
      .Data_out    (Data_out),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   assign Data_out  = darr[Data_Address];
   assign mem_rdata = dev_mem[mem_addr[8:2]];
   // Memory answers after n_wait cycles of mem_req; random noise otherwise
   assign mem_ready = mem_req ? (req_cnt == n_wait - 1) : junk_rdy;

   always @(posedge clk) begin
      if (mem_req && !mem_ready) req_cnt <= req_cnt + 1;
      else                       req_cnt <= 0;
      if (mem_req && mem_we && mem_ready) dev_mem[mem_addr[8:2]] <= mem_wdata;
      if (Data_enable) darr[Data_Address] <= Data_in;
      junk_rdy <= 1'($urandom_range(0, 1));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // Reset for two edges' worth: outputs checked while held and after release
   task automatic do_reset();
      rst     = 1'b1;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_mreq", mem_req, 0);
      chk("rst_mwe", mem_we, 0);
      chk("rst_de", Data_enable, 0);
      chk("rst_maddr", mem_addr, 0);
      chk("rst_mwdata", mem_wdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_hits", hit_count, 0);
      chk("rst_miss", miss_count, 0);
      chk("post_rst_stall", cpu_stall, 0);
      chk("post_rst_mreq", mem_req, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
      ref_hits = 0;
      ref_miss = 0;
   endtask

   // One CPU access; called at posedge+1, returns at posedge+1 after completion
   task automatic do_access(input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input int n);
      int          idx     = int'(addr[6:2]);
      logic [24:0] tg      = addr[31:7];
      int          w       = int'(addr[8:2]);
      bit          hit     = ref_valid[idx] && (ref_tag[idx] == tg);
      int          exp_cyc = we ? (1 + n) : (hit ? 1 : n + 2);
      int          exp_mrq = (!we && hit) ? 0 : n;
      int          exp_de  = we ? int'(hit) : int'(!hit);
      int          cyc = 0, mreq = 0, de = 0;
      logic [31:0] rd = '0, de_addr = '0, wa = '0, wdv = '0;
      bit          done = 1'b0;
      n_wait    = n;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr | 32'($urandom_range(0, 3));
      cpu_wdata = wd;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (mem_req) mreq++;
         if (mem_req && mem_we) begin
            wa  = mem_addr;
            wdv = mem_wdata;
         end
         if (Data_enable) begin
            de++;
            de_addr = 32'(Data_Address);
         end
         if (!cpu_stall) begin
            done = 1'b1;
            rd   = cpu_rdata;
         end
         @(posedge clk); #1;
         if (!done) begin
            // Disturb the request lines; the latched access must ignore this
            cpu_addr  = $urandom;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_wdata = $urandom;
         end
      end
      cpu_req = 1'b0;
      chk("done", 32'(done), 1);
      chk("cycles", cyc, exp_cyc);
      chk("mreq_cycles", mreq, exp_mrq);
      chk("de_pulses", de, exp_de);
      if (exp_de != 0) chk("de_index", de_addr, idx);
      if (we) begin
         ref_mem[w] = wd;
         chk("wr_addr", wa, addr & 32'hFFFF_FFFC);
         chk("wr_data", wdv, wd);
      end else begin
         chk("rdata", rd, ref_mem[w]);
         if (!hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
         end
      end
      if (hit) ref_hits = sat16(ref_hits + 1);
      else     ref_miss = sat16(ref_miss + 1);
      chk("hit_count", hit_count, ref_hits);
      chk("miss_count", miss_count, ref_miss);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      rst       = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      for (int i = 0; i < 128; i++) begin
         ref_mem[i] = $urandom;
         dev_mem[i] = ref_mem[i];
      end
      for (int i = 0; i < 32; i++) darr[i] = $urandom;
      ref_mem[16] = 32'hDEADBEEF;
      dev_mem[16] = 32'hDEADBEEF;
      @(posedge clk); #1;
      do_reset();

      // Directed: miss/fill, hit, conflict, store hit, store miss
      do_access(1'b0, 32'h040, 32'h0, 3);
      do_access(1'b0, 32'h040, 32'h0, 1);
      chk("dir_hits", hit_count, 1);
      chk("dir_miss", miss_count, 1);
      do_access(1'b0, 32'h0C0, 32'h0, 2);
      do_access(1'b0, 32'h040, 32'h0, 1);
      do_access(1'b1, 32'h040, 32'h12345678, 2);
      do_access(1'b0, 32'h040, 32'h0, 1);
      do_access(1'b1, 32'h100, 32'hCAFE0001, 1);
      do_access(1'b0, 32'h100, 32'h0, 2);

      // Randomized traffic over 4 tags x 32 indices
      for (int k = 0; k < 250; k++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
         do_access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(1, 4));
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("idle_stall", cpu_stall, 0);
            chk("idle_mreq", mem_req, 0);
            @(posedge clk); #1;
         end
      end

      // Reset in the middle of a read miss
      do_reset();
      do_access(1'b0, 32'h044, 32'h0, 1);
      do_access(1'b0, 32'h044, 32'h0, 1);
      n_wait   = 6;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h0C8;
      @(negedge clk);
      chk("abort_idle_stall", cpu_stall, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_rmiss_mreq", mem_req, 1);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      chk("abort_rst_mreq", mem_req, 0);
      chk("abort_rst_stall", cpu_stall, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_next_mreq", mem_req, 0);
      chk("abort_hits", hit_count, 0);
      chk("abort_miss", miss_count, 0);
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
      ref_hits = 0;
      ref_miss = 0;
      do_access(1'b0, 32'h044, 32'h0, 2);

      // Hit-counter saturation
      do_reset();
      do_access(1'b0, 32'h080, 32'h0, 1);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h080;
      stalls   = 0;
      for (int k = 0; k < 65541; k++) begin
         @(negedge clk);
         if (cpu_stall) stalls++;
         @(posedge clk); #1;
      end
      cpu_req  = 1'b0;
      ref_hits = sat16(ref_hits + 65541);
      chk("sat_stalls", stalls, 0);
      chk("sat_hits", hit_count, ref_hits);
      chk("sat_hits_ffff", hit_count, 32'h0000FFFF);
      chk("sat_miss", miss_count, ref_miss);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/l1_dcache_ctrl.md
# l1_dcache_ctrl

Direct-mapped, write-through, no-write-allocate L1 data-cache controller for the pipelined CPU. Sits between the MEM stage and main memory. It owns the tag/valid arrays and is the only master of the cache data array, driving its address, write-enable and write-data pins and consuming its asynchronous read output. One word per line, 2^mem_size lines.

## Interface
- bit_size, 32, data word width
- mem_size, 5, index width; line count = 2^mem_size
- addr_size, 32, CPU byte-address width; tag = addr[addr_size-1:mem_size+2], index = addr[mem_size+1:2], addr[1:0] ignored
- cnt_size, 16, width of hit/miss counters
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  access valid this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  addr_size  byte address
- cpu_wdata  in  bit_size  store data
- cpu_rdata  out  bit_size  load data
- cpu_stall  out  1  holds the pipeline; the access is consumed in the cycle cpu_stall is 0
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  addr_size  word-aligned memory address (addr[1:0] = 0)
- mem_wdata  out  bit_size  memory write data
- mem_rdata  in  bit_size  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current request this cycle
- Data_Address  out  mem_size  data-array index
- Data_enable  out  1  data-array write enable
- Data_in  out  bit_size  data-array write data
- Data_out  in  bit_size  data-array read data, combinational
- hit_count, miss_count  out  cnt_size  saturating access counters

## Operation
- FSM states: IDLE, RMISS, FILL, WMEM.
- hit = valid[index] && tag_arr[index] == tag. Computed combinationally in IDLE from cpu_addr.
- IDLE, no cpu_req: stall 0, no writes.
- IDLE, read hit: cpu_rdata = Data_out, stall 0, hit_count++.
- IDLE, read miss: latch addr, stall 1, miss_count++, go to RMISS.
- RMISS: mem_req 1, mem_we 0, mem_addr = latched word address, stall 1. On mem_ready, capture mem_rdata into fill_buf and go to FILL.
- FILL: Data_enable 1, Data_Address = latched index, Data_in = fill_buf. Set valid and tag. cpu_rdata = fill_buf, stall 0. Go to IDLE.
- IDLE, write:
  - Latch addr and data, stall 1, go to WMEM.
  - On a hit, Data_enable 1 this cycle with Data_in = cpu_wdata, and hit_count++.
  - On a miss, the array, tag and valid are untouched, and miss_count++.
- WMEM: mem_req 1, mem_we 1, mem_addr/mem_wdata = latched values. stall = !mem_ready. On mem_ready, go to IDLE.
- Data_Address = cpu_addr index in IDLE, latched index in all other states.
- Once latched, changes on cpu_* are ignored until the access completes.
- mem_ready while mem_req = 0 is ignored.
- Counters saturate at all-ones.

## Timing
- Reset, synchronous:
  - state IDLE, all valid bits 0, tags 0, fill_buf 0, counters 0.
  - Outputs during and after reset: cpu_stall 0, mem_req 0, mem_we 0, Data_enable 0, mem_addr 0, mem_wdata 0. cpu_rdata follows Data_out when idle.
- Reset asserted mid-RMISS/WMEM: abort, mem_req drops next cycle, no fill, pending access lost.
- Latency:
  - read hit 0 stall cycles.
  - read miss 1 + N + 1 cycles, where N is the cycle count until mem_ready (including that cycle); stall is low in FILL.
  - write is 1 + N cycles; stall is low in the mem_ready cycle.
- Minimum read miss with mem_ready held high: stall 1,1 then 0 (IDLE, RMISS, FILL).
- Back-to-back: the first IDLE cycle after FILL/WMEM evaluates the next request. A load from the just-filled index hits because the array and tag were written at the FILL edge.
- The array has no read-during-write bypass need: a write hit writes at the edge and completes later.

## Test plan
- Reset, then load 0x0000_0040 with mem_ready after 3 cycles and mem_rdata=0xDEADBEEF -> mem_req for 3 cycles, FILL cycle cpu_rdata=0xDEADBEEF with stall 0. A repeat load hits with 0 stall and hit_count=1, miss_count=1.
- Conflict: load 0x040 then load 0x0C0 (same index 0x10, different tag) -> second is a miss, refill replaces tag, a reload of 0x040 misses again.
- Store hit 0x040 data 0x12345678 -> Data_enable pulses one cycle at index 0x10, mem write issued, subsequent load returns 0x12345678 with no miss.
- Store miss 0x100 -> no Data_enable, mem_we=1 with addr 0x100, next load 0x100 misses.
- rst asserted during RMISS -> mem_req 0 next cycle, valid cleared, prior hit address now misses, counters 0.
- 2^cnt_size+5 read hits -> hit_count holds at 0xFFFF.
